// File: rtl/ucsbece154b_refill_engine.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154b_refill_engine
// Brief    : Instruction-cache miss refill engine. After an accepted miss it
//            waits DELAY_CYCLES, then streams one block from a combinational
//            instruction memory, one word per cycle, tagged with its in-block
//            index and a last flag. Sequential or critical-word-first order.
//            A one-entry pending slot allows back-to-back refills; flush_i
//            aborts both the active and the pending refill.
// Revision : 1.0 - initial release
// ============================================================================
module ucsbece154b_refill_engine #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BLOCK_SIZE   = 4,
    parameter int DELAY_CYCLES = 5,
    parameter int CWF          = 1
) (
    input  logic                          clk,
    input  logic                          reset_i,
    input  logic                          req_valid_i,
    input  logic [ADDR_WIDTH-1:0]         req_addr_i,
    output logic                          req_ready_o,
    input  logic                          flush_i,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    output logic                          rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [$clog2(BLOCK_SIZE)-1:0] rsp_word_o,
    output logic                          rsp_last_o,
    output logic                          busy_o
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int BYTE_BITS  = $clog2(DATA_WIDTH / 8);
    localparam int BLOCK_BITS = $clog2(BLOCK_SIZE);
    localparam int OFF_LSB    = BYTE_BITS;
    localparam int OFF_MSB    = BLOCK_BITS + BYTE_BITS - 1;
    localparam int TAG_LSB    = BLOCK_BITS + BYTE_BITS;
    localparam int DLY_W      = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    localparam logic [DLY_W-1:0]      DLY_LAST  = (DELAY_CYCLES > 0) ? DLY_W'(DELAY_CYCLES - 1) : '0;
    localparam logic [BLOCK_BITS:0]   BEAT_LAST = (BLOCK_BITS + 1)'(BLOCK_SIZE - 1);
    localparam logic [DLY_W-1:0]      DLY_ONE   = DLY_W'(1);
    localparam logic [BLOCK_BITS:0]   BEAT_ONE  = (BLOCK_BITS + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    // A fresh refill skips the wait state entirely when there is no latency
    localparam state_t ST_START = (DELAY_CYCLES > 0) ? ST_DELAY : ST_READ;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                  state_q,       state_d;
    logic [ADDR_WIDTH-1:0]   active_addr_q, active_addr_d;
    logic                    pend_valid_q,  pend_valid_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q,   pend_addr_d;
    logic [DLY_W-1:0]        dly_cnt_q,     dly_cnt_d;
    logic [BLOCK_BITS:0]     beat_q,        beat_d;
    logic                    rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q,    rsp_data_d;
    logic [BLOCK_BITS-1:0]   rsp_word_q,    rsp_word_d;
    logic                    rsp_last_q,    rsp_last_d;

    logic                    w_accept;
    logic                    w_last_beat;
    logic [BLOCK_BITS-1:0]   w_off;
    logic [BLOCK_BITS-1:0]   w_idx;
    logic                    w_do_start;
    logic [ADDR_WIDTH-1:0]   w_start_addr;
    logic                    w_unused_bits;

    // Byte-within-word bits of the miss address never reach memory
    assign w_unused_bits = ^active_addr_q[BYTE_BITS-1:0];

    assign req_ready_o = ~pend_valid_q & ~flush_i;
    assign w_accept    = req_valid_i & req_ready_o;
    assign busy_o      = (state_q != ST_IDLE);

    assign w_off       = active_addr_q[OFF_MSB:OFF_LSB];
    assign w_last_beat = (state_q == ST_READ) && (beat_q == BEAT_LAST);

    // Word index of the current beat; wrap comes from the BLOCK_BITS-wide add
    always_comb begin
        w_idx = beat_q[BLOCK_BITS-1:0];
        if (CWF != 0) begin
            w_idx = w_off + beat_q[BLOCK_BITS-1:0];
        end
    end

    // Memory address: block base plus current word index (index 0 when not reading)
    always_comb begin
        mem_addr_o = {active_addr_q[ADDR_WIDTH-1:TAG_LSB], {BLOCK_BITS{1'b0}}, {BYTE_BITS{1'b0}}};
        if (state_q == ST_READ) begin
            mem_addr_o = {active_addr_q[ADDR_WIDTH-1:TAG_LSB], w_idx, {BYTE_BITS{1'b0}}};
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_word_o  = rsp_word_q;
    assign rsp_last_o  = rsp_last_q;

    // Next-state logic: sequencing, pending slot handling and beat capture
    always_comb begin
        state_d       = state_q;
        active_addr_d = active_addr_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        dly_cnt_d     = dly_cnt_q;
        beat_d        = beat_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_word_d    = rsp_word_q;
        rsp_last_d    = rsp_last_q;
        w_do_start    = 1'b0;
        w_start_addr  = req_addr_i;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_do_start = 1'b1;
                end
            end

            ST_DELAY: begin
                if (w_accept) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = req_addr_i;
                end
                if (dly_cnt_q == DLY_LAST) begin
                    state_d = ST_READ;
                    beat_d  = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_ONE;
                end
            end

            ST_READ: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_rdata_i;
                rsp_word_d  = w_idx;
                rsp_last_d  = w_last_beat;
                if (w_last_beat) begin
                    // A request landing on the last beat can only be accepted
                    // with the slot empty, so it never competes with pending.
                    if (w_accept) begin
                        w_do_start = 1'b1;
                    end else if (pend_valid_q) begin
                        w_do_start   = 1'b1;
                        w_start_addr = pend_addr_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    beat_d = beat_q + BEAT_ONE;
                    if (w_accept) begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = req_addr_i;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_do_start) begin
            active_addr_d = w_start_addr;
            state_d       = ST_START;
            dly_cnt_d     = '0;
            beat_d        = '0;
        end

        // Abort wins over any request or final beat in the same cycle
        if (flush_i) begin
            state_d      = ST_IDLE;
            pend_valid_d = 1'b0;
            rsp_valid_d  = 1'b0;
            dly_cnt_d    = '0;
            beat_d       = '0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= ST_IDLE;
            active_addr_q <= '0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            dly_cnt_q     <= '0;
            beat_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_word_q    <= '0;
            rsp_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_addr_q <= active_addr_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            dly_cnt_q     <= dly_cnt_d;
            beat_q        <= beat_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_word_q    <= rsp_word_d;
            rsp_last_q    <= rsp_last_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_refill_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucsbece154b_refill_engine
// Brief    : Directed self-checking bench for the refill engine. Three
//            instances: sequential order, critical-word-first, and zero
//            latency with 8-word blocks. Memory is a fixed address function.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucsbece154b_refill_engine;

    localparam int C_NDUT = 3;

    logic        clk;
    logic        r_rst_n;
    logic        r_req_valid [C_NDUT];
    logic [31:0] r_req_addr  [C_NDUT];
    logic        r_flush     [C_NDUT];
    logic        w_req_ready [C_NDUT];
    logic [31:0] w_mem_addr  [C_NDUT];
    logic [31:0] w_mem_rdata [C_NDUT];
    logic        w_rsp_valid [C_NDUT];
    logic [31:0] w_rsp_data  [C_NDUT];
    logic [2:0]  w_rsp_word  [C_NDUT];
    logic        w_rsp_last  [C_NDUT];
    logic        w_busy      [C_NDUT];
    logic [1:0]  w_word_seq;
    logic [1:0]  w_word_cwf;

    int n_checks = 0;
    int n_errors = 0;

    // Instruction memory model: every word derives from its own byte address
    function automatic logic [31:0] f_mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    for (genvar g = 0; g < C_NDUT; g++) begin : g_mem
        assign w_mem_rdata[g] = f_mem(w_mem_addr[g]);
    end

    assign w_rsp_word[0] = {1'b0, w_word_seq};
    assign w_rsp_word[1] = {1'b0, w_word_cwf};

    ucsbece154b_refill_engine #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(4), .DELAY_CYCLES(5), .CWF(0)
    ) u_seq (
        .clk(clk), .reset_i(r_rst_n),
        .req_valid_i(r_req_valid[0]), .req_addr_i(r_req_addr[0]), .req_ready_o(w_req_ready[0]),
        .flush_i(r_flush[0]), .mem_addr_o(w_mem_addr[0]), .mem_rdata_i(w_mem_rdata[0]),
        .rsp_valid_o(w_rsp_valid[0]), .rsp_data_o(w_rsp_data[0]), .rsp_word_o(w_word_seq),
        .rsp_last_o(w_rsp_last[0]), .busy_o(w_busy[0])
    );

    ucsbece154b_refill_engine #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(4), .DELAY_CYCLES(5), .CWF(1)
    ) u_cwf (
        .clk(clk), .reset_i(r_rst_n),
        .req_valid_i(r_req_valid[1]), .req_addr_i(r_req_addr[1]), .req_ready_o(w_req_ready[1]),
        .flush_i(r_flush[1]), .mem_addr_o(w_mem_addr[1]), .mem_rdata_i(w_mem_rdata[1]),
        .rsp_valid_o(w_rsp_valid[1]), .rsp_data_o(w_rsp_data[1]), .rsp_word_o(w_word_cwf),
        .rsp_last_o(w_rsp_last[1]), .busy_o(w_busy[1])
    );

    ucsbece154b_refill_engine #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(8), .DELAY_CYCLES(0), .CWF(1)
    ) u_d0 (
        .clk(clk), .reset_i(r_rst_n),
        .req_valid_i(r_req_valid[2]), .req_addr_i(r_req_addr[2]), .req_ready_o(w_req_ready[2]),
        .flush_i(r_flush[2]), .mem_addr_o(w_mem_addr[2]), .mem_rdata_i(w_mem_rdata[2]),
        .rsp_valid_o(w_rsp_valid[2]), .rsp_data_o(w_rsp_data[2]), .rsp_word_o(w_rsp_word[2]),
        .rsp_last_o(w_rsp_last[2]), .busy_o(w_busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that starts a refill of addr on instance d
    task automatic expect_block(input int d, input int dly, input int bs, input bit cwf,
                                input logic [31:0] addr, input string tag);
        logic [31:0] base;
        logic [31:0] ea;
        int          off;
        int          idx;
        base = addr & ~(32'(bs * 4) - 32'd1);
        off  = int'((addr >> 2) % 32'(bs));
        for (int n = 0; n < dly; n++) begin
            tick();
            check({tag, "_wait_valid"}, 64'(w_rsp_valid[d]), 64'd0);
        end
        for (int i = 0; i < bs; i++) begin
            idx = cwf ? ((off + i) % bs) : i;
            ea  = base + 32'(idx * 4);
            check({tag, "_mem_addr"}, 64'(w_mem_addr[d]), 64'(ea));
            tick();
            check({tag, "_valid"}, 64'(w_rsp_valid[d]), 64'd1);
            check({tag, "_word"},  64'(w_rsp_word[d]),  64'(idx));
            check({tag, "_data"},  64'(w_rsp_data[d]),  64'(f_mem(ea)));
            check({tag, "_last"},  64'(w_rsp_last[d]),  64'(i == bs - 1));
        end
    endtask

    task automatic check_zero_outputs(input int d, input string tag);
        check({tag, "_valid"},    64'(w_rsp_valid[d]), 64'd0);
        check({tag, "_data"},     64'(w_rsp_data[d]),  64'd0);
        check({tag, "_word"},     64'(w_rsp_word[d]),  64'd0);
        check({tag, "_last"},     64'(w_rsp_last[d]),  64'd0);
        check({tag, "_mem_addr"}, 64'(w_mem_addr[d]),  64'd0);
        check({tag, "_busy"},     64'(w_busy[d]),      64'd0);
    endtask

    // Single request on instance d held for one accepting edge
    task automatic issue(input int d, input logic [31:0] addr);
        r_req_valid[d] = 1'b1;
        r_req_addr[d]  = addr;
        tick();
        r_req_valid[d] = 1'b0;
    endtask

    initial begin
        int stray;
        int busy_seen;

        r_rst_n = 1'b0;
        for (int d = 0; d < C_NDUT; d++) begin
            r_req_valid[d] = 1'b0;
            r_req_addr[d]  = '0;
            r_flush[d]     = 1'b0;
        end
        tick();
        tick();
        check_zero_outputs(0, "rst_seq");
        check_zero_outputs(1, "rst_cwf");
        check_zero_outputs(2, "rst_d0");
        r_rst_n = 1'b1;
        tick();
        check("rst_ready", 64'(w_req_ready[0]), 64'd1);

        // Sequential order: 0x48 -> 0x40,0x44,0x48,0x4C
        issue(0, 32'h0000_0048);
        check("seq_busy", 64'(w_busy[0]), 64'd1);
        expect_block(0, 5, 4, 1'b0, 32'h0000_0048, "seq");
        check("seq_idle_after", 64'(w_busy[0]), 64'd0);
        tick();
        check("seq_valid_drop", 64'(w_rsp_valid[0]), 64'd0);

        // Critical-word-first, then a request on the last beat with slot empty
        issue(1, 32'h0000_0048);
        fork
            expect_block(1, 5, 4, 1'b1, 32'h0000_0048, "cwf");
            begin
                repeat (8) tick();
                r_req_valid[1] = 1'b1;
                r_req_addr[1]  = 32'h0000_01C4;
                check("lastbeat_ready", 64'(w_req_ready[1]), 64'd1);
                tick();
                r_req_valid[1] = 1'b0;
                check("lastbeat_no_idle", 64'(w_busy[1]), 64'd1);
            end
        join
        expect_block(1, 5, 4, 1'b1, 32'h0000_01C4, "lastbeat");
        check("lastbeat_idle", 64'(w_busy[1]), 64'd0);
        tick();

        // Back-to-back: A, B into pending during A's wait, C refused on A's last beat
        issue(0, 32'h0000_0100);
        fork
            begin
                expect_block(0, 5, 4, 1'b0, 32'h0000_0100, "b2b_a");
                expect_block(0, 5, 4, 1'b0, 32'h0000_0200, "b2b_b");
                expect_block(0, 5, 4, 1'b0, 32'h0000_0300, "b2b_c");
            end
            begin
                r_req_valid[0] = 1'b1;
                r_req_addr[0]  = 32'h0000_0200;
                check("b2b_b_ready", 64'(w_req_ready[0]), 64'd1);
                tick();
                r_req_valid[0] = 1'b0;
                check("b2b_pend_full", 64'(w_req_ready[0]), 64'd0);
                repeat (7) tick();
                r_req_valid[0] = 1'b1;
                r_req_addr[0]  = 32'h0000_0300;
                check("b2b_c_refused", 64'(w_req_ready[0]), 64'd0);
                tick();
                check("b2b_c_ready_back", 64'(w_req_ready[0]), 64'd1);
                tick();
                r_req_valid[0] = 1'b0;
            end
        join
        check("b2b_idle", 64'(w_busy[0]), 64'd0);
        tick();

        // Flush on the second beat while a request is pending
        issue(0, 32'h0000_0500);
        issue(0, 32'h0000_0600);
        repeat (4) tick();
        check("fl_beat0_addr", 64'(w_mem_addr[0]), 64'h500);
        tick();
        check("fl_beat0_valid", 64'(w_rsp_valid[0]), 64'd1);
        r_flush[0] = 1'b1;
        #1;
        check("fl_ready_low", 64'(w_req_ready[0]), 64'd0);
        tick();
        r_flush[0] = 1'b0;
        #1;
        check("fl_valid_low", 64'(w_rsp_valid[0]), 64'd0);
        check("fl_busy_low", 64'(w_busy[0]), 64'd0);
        check("fl_ready_back", 64'(w_req_ready[0]), 64'd1);
        stray     = 0;
        busy_seen = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (w_rsp_valid[0] !== 1'b0) stray++;
            if (w_busy[0] !== 1'b0) busy_seen++;
        end
        check("fl_no_stray_beats", 64'(stray), 64'd0);
        check("fl_pending_dropped", 64'(busy_seen), 64'd0);

        // Zero latency, 8-word block, critical word 7 -> 7,0,1..6
        issue(2, 32'h0000_003C);
        expect_block(2, 0, 8, 1'b1, 32'h0000_003C, "d0");
        check("d0_idle", 64'(w_busy[2]), 64'd0);
        tick();

        // Asynchronous reset in the middle of a block
        issue(2, 32'h0000_0080);
        tick();
        tick();
        check("rmid_valid_before", 64'(w_rsp_valid[2]), 64'd1);
        #2;
        r_rst_n = 1'b0;
        #1;
        check_zero_outputs(2, "rmid");
        tick();
        tick();
        r_rst_n = 1'b1;
        stray = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (w_rsp_valid[2] !== 1'b0 || w_busy[2] !== 1'b0) stray++;
        end
        check("rmid_no_beats", 64'(stray), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/ucsbece154b_refill_engine.md
Name: ucsbece154b_refill_engine

Overview:
- Parametrised instruction-cache miss refill engine. Sits between the icache miss logic and a combinational instruction memory.
- On an accepted miss request it waits a programmable latency, then streams one full block, one word per cycle. Each word is tagged with its in-block index and a last flag.
- Word order is selectable: sequential from word 0, or critical-word-first with wrap.
- Holds a one-entry pending request queue for back-to-back refills and supports synchronous flush/abort.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width (power of two, ≥8). BYTE_BITS = log2(DATA_WIDTH/8).
- BLOCK_SIZE, 4, words per block (power of two, ≥2). BLOCK_BITS = log2(BLOCK_SIZE).
- DELAY_CYCLES, 5, wait cycles between request start and first memory read (0 allowed).
- CWF, 1, 1 = critical-word-first wrap order, 0 = sequential from word 0.

Ports:
- clk  in  1  clock, rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  miss request valid.
- req_addr_i  in  ADDR_WIDTH  missed byte address.
- req_ready_o  out  1  request accepted on a cycle where req_valid_i & req_ready_o.
- flush_i  in  1  synchronous abort of the active and pending refills.
- mem_addr_o  out  ADDR_WIDTH  memory byte address (combinational from state).
- mem_rdata_i  in  DATA_WIDTH  memory read data (combinational in mem_addr_o).
- rsp_valid_o  out  1  rsp_* valid this cycle.
- rsp_data_o  out  DATA_WIDTH  refill word.
- rsp_word_o  out  BLOCK_BITS  in-block word index of rsp_data_o.
- rsp_last_o  out  1  final word of the block.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - state IDLE; pending slot empty; all counters 0.
  - rsp_valid_o=0, rsp_data_o=0, rsp_word_o=0, rsp_last_o=0, mem_addr_o=0.
- States: IDLE, DELAY, READ.
- req_ready_o = ~pend_valid & ~flush_i. Requests are accepted in any state while the pending slot is empty.
- Accept in IDLE:
  - Latch address into the active register.
  - DELAY_CYCLES>0: go to DELAY, dly_cnt=0.
  - DELAY_CYCLES=0: go straight to READ, beat=0.
- Accept in DELAY, or in READ on a non-last beat: store in the pending slot.
- Accept on the last READ cycle: start it directly, exactly as an accept in IDLE. It is not stored in the pending slot.
- DELAY: dly_cnt increments each cycle. When dly_cnt==DELAY_CYCLES-1, go to READ with beat=0.
- READ, beat i (0..BLOCK_SIZE-1):
  - idx = CWF ? (off+i) mod BLOCK_SIZE : i, where off = active_addr[BLOCK_BITS+BYTE_BITS-1:BYTE_BITS]. Wrap is natural modulo of BLOCK_BITS-wide addition.
  - mem_addr_o = {active_addr[ADDR_WIDTH-1:BLOCK_BITS+BYTE_BITS], idx, BYTE_BITS'b0}.
  - At the clock edge: rsp_data_o<=mem_rdata_i, rsp_word_o<=idx, rsp_last_o<=(i==BLOCK_SIZE-1), rsp_valid_o<=1.
- After the last beat:
  - New request accepted this cycle: start it.
  - Otherwise, pending valid: move pending to active, clear the slot, enter DELAY (or READ if DELAY_CYCLES=0). No IDLE bubble.
  - Otherwise: IDLE.
- rsp_valid_o is registered. It is low in every cycle not immediately following a READ cycle.
- mem_addr_o outside READ holds the block base of the active address with idx=0. It is don't-care for checking.
- Latency: request accepted at edge k; beat i is visible on rsp_* during the cycle after edge k+DELAY_CYCLES+1+i. Exactly BLOCK_SIZE consecutive beats per refill, every index 0..BLOCK_SIZE-1 exactly once.
- Flush (flush_i=1 at an edge):
  - Next state IDLE, pending cleared, rsp_valid_o<=0, counters cleared.
  - Flush beats a simultaneous request (req_ready_o is low) and a simultaneous last beat.
- Reset mid-refill: immediate abort, no further beats.
- Counter widths: dly_cnt sized for DELAY_CYCLES, minimum 1 bit; beat counter BLOCK_BITS+1 bits.

Test Plan:
- Defaults, CWF=0, req 0x0000_0048 at edge k → beats at k+6..k+9, addrs 0x40,0x44,0x48,0x4C, rsp_word 0,1,2,3, rsp_last only on 4th, then busy_o=0.
- CWF=1, req 0x0000_0048 → addrs 0x48,0x4C,0x40,0x44, rsp_word 2,3,0,1; data matches memory model at each address.
- Back-to-back: req A accepted, req B during A's DELAY (req_ready_o then drops until B starts), req C on A's last beat is refused → B's DELAY starts the cycle after A's last beat; C is accepted once req_ready_o returns.
- Request on the last READ cycle with pending empty → started immediately, first beat DELAY_CYCLES+1 cycles later, no IDLE cycle.
- flush_i on 2nd beat with pending valid → rsp_valid_o low next cycle, pending dropped, req_ready_o=1 next cycle, no stray beats for 20 cycles.
- DELAY_CYCLES=0, BLOCK_SIZE=8, CWF=1, req offset 7 → first beat the cycle after acceptance, words 7,0,1..6; reset_i pulsed low mid-block → all outputs 0 asynchronously.
